// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//
// Supervises one CC_PLL instance from the CLK_REF domain. It synchronizes
// the lock status pair, filters short lock glitches, sequences the release
// of the downstream reset, and flags lock loss and lock-acquisition timeout.
// Sticky status bits and a saturating relock counter are kept for firmware.
//
// Optional build macro:
//   LOCK_SUPV_IRQ_EN - adds output irq, a one-cycle pulse on each entry to
//                      LOST or FAIL. Without it there is no irq port.
//
// Ports:
//   CLK_REF              in   reference clock, rising edge
//   USR_LOCKED_STDY_RST  in   asynchronous active-high reset
//   USR_PLL_LOCKED       in   PLL lock (asynchronous, synchronized here)
//   USR_PLL_LOCKED_STDY  in   PLL steady lock (asynchronous, synchronized here)
//   clr_status           in   synchronous clear of lock_lost and timeout
//   sys_rst              out  active-high reset for the PLL clock domain
//   ready                out  high while in RUN
//   steady               out  ready qualified by synchronized steady lock
//   lock_lost            out  sticky, set on entry to LOST
//   timeout              out  sticky, set on entry to FAIL
//   relock_cnt[7:0]      out  number of LOST entries, saturating at 255
//   state[2:0]           out  FSM state (0 WAIT_LOCK .. 5 FAIL)
//   irq                  out  (LOCK_SUPV_IRQ_EN only) event pulse
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
  parameter int FILTER_CYC  = 16,
  parameter int HOLD_CYC    = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic       CLK_REF,
  input  logic       USR_LOCKED_STDY_RST,
  input  logic       USR_PLL_LOCKED,
  input  logic       USR_PLL_LOCKED_STDY,
  input  logic       clr_status,
  output logic       sys_rst,
  output logic       ready,
  output logic       steady,
  output logic       lock_lost,
  output logic       timeout,
  output logic [7:0] relock_cnt,
  output logic [2:0] state
`ifdef LOCK_SUPV_IRQ_EN
  ,
  output logic       irq
`endif
);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_FILTER    = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  // Terminal counts: the counter runs 0..N-1 inside a state.
  localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(FILTER_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  logic         locked_meta_r;
  logic         locked_sync_r;
  logic         stdy_meta_r;
  logic         stdy_sync_r;
  logic         locked_s;
  logic         stdy_s;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  logic         lost_entry_s;
  logic         fail_entry_s;

  logic         sys_rst_r;
  logic         ready_r;
  logic         steady_r;
  logic         lock_lost_r;
  logic         timeout_r;
  logic [7:0]   relock_cnt_r;

  // Two-flop synchronizers for the asynchronous lock indications.
  always_ff @(posedge CLK_REF or posedge USR_LOCKED_STDY_RST) begin
    if (USR_LOCKED_STDY_RST) begin
      locked_meta_r <= 1'b0;
      locked_sync_r <= 1'b0;
      stdy_meta_r   <= 1'b0;
      stdy_sync_r   <= 1'b0;
    end else begin
      locked_meta_r <= USR_PLL_LOCKED;
      locked_sync_r <= locked_meta_r;
      stdy_meta_r   <= USR_PLL_LOCKED_STDY;
      stdy_sync_r   <= stdy_meta_r;
    end
  end

  assign locked_s = locked_sync_r;
  assign stdy_s   = stdy_sync_r;

  // FSM state and shared cycle counter registers.
  always_ff @(posedge CLK_REF or posedge USR_LOCKED_STDY_RST) begin
    if (USR_LOCKED_STDY_RST) begin
      state_r <= ST_WAIT_LOCK;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and counter logic; the counter is cleared on every transition.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt_s = ST_FILTER;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_nxt_s = ST_FAIL;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_FILTER: begin
        // A drop here is a glitch, not a loss: back to WAIT_LOCK quietly.
        if (!locked_s) begin
          state_nxt_s = ST_WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == FILTER_LAST) begin
          state_nxt_s = ST_HOLD;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (!locked_s) begin
          state_nxt_s = ST_LOST;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == HOLD_LAST) begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_RUN: begin
        // Only the lock bit matters here; steady loss just clears steady.
        if (!locked_s) begin
          state_nxt_s = ST_LOST;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_LOST: begin
        state_nxt_s = ST_WAIT_LOCK;
        cnt_nxt_s   = CNT_ZERO;
      end
      ST_FAIL: begin
        // A late lock is still accepted.
        if (locked_s) begin
          state_nxt_s = ST_FILTER;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_FAIL;
        end
      end
      default: begin
        state_nxt_s = ST_WAIT_LOCK;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // LOST is never re-entered from itself, but FAIL holds; detect true entries.
  assign lost_entry_s = (state_nxt_s == ST_LOST) && (state_r != ST_LOST);
  assign fail_entry_s = (state_nxt_s == ST_FAIL) && (state_r != ST_FAIL);

  // Registered outputs, decoded from the next state so they change with it.
  always_ff @(posedge CLK_REF or posedge USR_LOCKED_STDY_RST) begin
    if (USR_LOCKED_STDY_RST) begin
      sys_rst_r <= 1'b1;
      ready_r   <= 1'b0;
      steady_r  <= 1'b0;
    end else begin
      sys_rst_r <= (state_nxt_s != ST_RUN);
      ready_r   <= (state_nxt_s == ST_RUN);
      steady_r  <= (state_nxt_s == ST_RUN) && stdy_s;
    end
  end

  // Sticky status and relock counter; a set event wins over clr_status.
  always_ff @(posedge CLK_REF or posedge USR_LOCKED_STDY_RST) begin
    if (USR_LOCKED_STDY_RST) begin
      lock_lost_r  <= 1'b0;
      timeout_r    <= 1'b0;
      relock_cnt_r <= 8'd0;
    end else begin
      if (lost_entry_s) begin
        lock_lost_r <= 1'b1;
      end else if (clr_status) begin
        lock_lost_r <= 1'b0;
      end else begin
        lock_lost_r <= lock_lost_r;
      end

      if (fail_entry_s) begin
        timeout_r <= 1'b1;
      end else if (clr_status) begin
        timeout_r <= 1'b0;
      end else begin
        timeout_r <= timeout_r;
      end

      if (lost_entry_s && (relock_cnt_r != 8'hFF)) begin
        relock_cnt_r <= relock_cnt_r + 8'd1;
      end else begin
        relock_cnt_r <= relock_cnt_r;
      end
    end
  end

`ifdef LOCK_SUPV_IRQ_EN
  logic irq_r;

  // Event pulse on entry to LOST or FAIL; independent of clr_status.
  always_ff @(posedge CLK_REF or posedge USR_LOCKED_STDY_RST) begin
    if (USR_LOCKED_STDY_RST) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= lost_entry_s || fail_entry_s;
    end
  end

  assign irq = irq_r;
`endif

  assign sys_rst    = sys_rst_r;
  assign ready      = ready_r;
  assign steady     = steady_r;
  assign lock_lost  = lock_lost_r;
  assign timeout    = timeout_r;
  assign relock_cnt = relock_cnt_r;
  assign state      = state_r;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Self-checking bench for pll_lock_supervisor with default parameters.
// A behavioural model (delay-line queues for the synchronizers, phase plus
// time-in-phase bookkeeping for the sequencing) is compared against every
// DUT output on each falling edge. Directed sequences pin the model with
// hand-computed literal expectations, then randomized lock/steady/clear
// activity runs against the model.
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

  localparam int FILTER_CYC  = 16;
  localparam int HOLD_CYC    = 8;
  localparam int TIMEOUT_CYC = 1024;

  localparam int P_WAIT   = 0;
  localparam int P_FILTER = 1;
  localparam int P_HOLD   = 2;
  localparam int P_RUN    = 3;
  localparam int P_LOST   = 4;
  localparam int P_FAIL   = 5;

  logic       CLK_REF;
  logic       USR_LOCKED_STDY_RST;
  logic       USR_PLL_LOCKED;
  logic       USR_PLL_LOCKED_STDY;
  logic       clr_status;
  logic       sys_rst;
  logic       ready;
  logic       steady;
  logic       lock_lost;
  logic       timeout;
  logic [7:0] relock_cnt;
  logic [2:0] state;
`ifdef LOCK_SUPV_IRQ_EN
  logic       irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pll_lock_supervisor dut (
    .CLK_REF             (CLK_REF),
    .USR_LOCKED_STDY_RST (USR_LOCKED_STDY_RST),
    .USR_PLL_LOCKED      (USR_PLL_LOCKED),
    .USR_PLL_LOCKED_STDY (USR_PLL_LOCKED_STDY),
    .clr_status          (clr_status),
    .sys_rst             (sys_rst),
    .ready               (ready),
    .steady              (steady),
    .lock_lost           (lock_lost),
    .timeout             (timeout),
    .relock_cnt          (relock_cnt),
    .state               (state)
`ifdef LOCK_SUPV_IRQ_EN
    ,
    .irq                 (irq)
`endif
  );

  initial CLK_REF = 1'b0;
  always #5 CLK_REF = ~CLK_REF;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit lkq[$];
  bit stq[$];
  int m_ph, m_age, m_relock;
  bit m_lost, m_to, m_steady, m_irq;
  int nph;
  bit ls, ss;

  always @(posedge CLK_REF or posedge USR_LOCKED_STDY_RST) begin
    if (USR_LOCKED_STDY_RST) begin
      lkq = '{1'b0, 1'b0};
      stq = '{1'b0, 1'b0};
      m_ph = P_WAIT; m_age = 0; m_relock = 0;
      m_lost = 1'b0; m_to = 1'b0; m_steady = 1'b0; m_irq = 1'b0;
    end else begin
      // value seen by the design is the one sampled two edges ago
      ls = lkq.pop_front(); lkq.push_back(USR_PLL_LOCKED);
      ss = stq.pop_front(); stq.push_back(USR_PLL_LOCKED_STDY);
      nph = m_ph;
      case (m_ph)
        P_WAIT:   if (ls) nph = P_FILTER; else if (m_age >= TIMEOUT_CYC - 1) nph = P_FAIL;
        P_FILTER: if (!ls) nph = P_WAIT; else if (m_age >= FILTER_CYC - 1) nph = P_HOLD;
        P_HOLD:   if (!ls) nph = P_LOST; else if (m_age >= HOLD_CYC - 1) nph = P_RUN;
        P_RUN:    if (!ls) nph = P_LOST;
        P_LOST:   nph = P_WAIT;
        P_FAIL:   if (ls) nph = P_FILTER;
        default:  nph = P_WAIT;
      endcase
      m_irq = (nph != m_ph) && (nph == P_LOST || nph == P_FAIL);
      if (nph == P_LOST) begin
        m_lost = 1'b1;
        if (m_relock < 255) m_relock = m_relock + 1;
      end else if (clr_status) m_lost = 1'b0;
      if (nph == P_FAIL && m_ph != P_FAIL) m_to = 1'b1;
      else if (clr_status) m_to = 1'b0;
      m_steady = (nph == P_RUN) && ss;
      m_age = (nph == m_ph) ? m_age + 1 : 0;
      m_ph = nph;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK_REF) begin
    if (!USR_LOCKED_STDY_RST) begin
      chk("m_state",     32'(state),      m_ph);
      chk("m_sys_rst",   32'(sys_rst),    (m_ph != P_RUN) ? 1 : 0);
      chk("m_ready",     32'(ready),      (m_ph == P_RUN) ? 1 : 0);
      chk("m_steady",    32'(steady),     int'(m_steady));
      chk("m_lock_lost", 32'(lock_lost),  int'(m_lost));
      chk("m_timeout",   32'(timeout),    int'(m_to));
      chk("m_relock",    32'(relock_cnt), m_relock);
`ifdef LOCK_SUPV_IRQ_EN
      chk("m_irq",       32'(irq),        int'(m_irq));
`endif
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge CLK_REF);
    @(negedge CLK_REF);
  endtask

  task automatic do_reset();
    USR_LOCKED_STDY_RST = 1'b1;
    #2;
    chk("rst_sys_rst",   32'(sys_rst),    1);
    chk("rst_ready",     32'(ready),      0);
    chk("rst_steady",    32'(steady),     0);
    chk("rst_lock_lost", 32'(lock_lost),  0);
    chk("rst_timeout",   32'(timeout),    0);
    chk("rst_relock",    32'(relock_cnt), 0);
    chk("rst_state",     32'(state),      0);
`ifdef LOCK_SUPV_IRQ_EN
    chk("rst_irq",       32'(irq),        0);
`endif
    @(negedge CLK_REF);
    USR_LOCKED_STDY_RST = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int run;
    USR_LOCKED_STDY_RST = 1'b0;
    USR_PLL_LOCKED      = 1'b0;
    USR_PLL_LOCKED_STDY = 1'b0;
    clr_status          = 1'b0;
    #1;
    do_reset();

    // clean lock: sampled at edge 0
    USR_PLL_LOCKED = 1'b1;
    tick(3);  chk("lock_e2_filter", 32'(state), 1);
    tick(15); chk("lock_e17_filter", 32'(state), 1);
    tick(1);  chk("lock_e18_hold", 32'(state), 2);
    tick(7);  chk("lock_e25_hold", 32'(state), 2);
              chk("lock_e25_sys_rst", 32'(sys_rst), 1);
    tick(1);  chk("lock_e26_run", 32'(state), 3);
              chk("lock_e26_sys_rst", 32'(sys_rst), 0);
              chk("lock_e26_ready", 32'(ready), 1);

    // loss in RUN: falls at sampled edge k
    USR_PLL_LOCKED = 1'b0;
    tick(2);  chk("loss_k1_run", 32'(state), 3);
    tick(1);  chk("loss_k2_lost", 32'(state), 4);
              chk("loss_k2_sys_rst", 32'(sys_rst), 1);
              chk("loss_k2_lock_lost", 32'(lock_lost), 1);
              chk("loss_k2_relock", 32'(relock_cnt), 1);
    tick(1);  chk("loss_k3_wait", 32'(state), 0);

    // clear sticky flag
    clr_status = 1'b1; tick(1); clr_status = 1'b0;
    chk("clr_lock_lost", 32'(lock_lost), 0);

    // relock, then steady follows STDY only
    USR_PLL_LOCKED = 1'b1;
    tick(30); chk("relock_run", 32'(state), 3);
    USR_PLL_LOCKED_STDY = 1'b1;
    tick(2);  chk("stdy_j1_low", 32'(steady), 0);
    tick(1);  chk("stdy_j2_high", 32'(steady), 1);
              chk("stdy_j2_run", 32'(state), 3);
    USR_PLL_LOCKED_STDY = 1'b0;
    tick(2);  chk("stdy_drop_j1", 32'(steady), 1);
    tick(1);  chk("stdy_drop_j2", 32'(steady), 0);
              chk("stdy_drop_run", 32'(state), 3);

    // clr_status coincident with LOST entry: set wins
    USR_PLL_LOCKED = 1'b0;
    tick(2); clr_status = 1'b1;
    tick(1); clr_status = 1'b0;
    chk("coinc_lost", 32'(state), 4);
    chk("coinc_lock_lost", 32'(lock_lost), 1);
    chk("coinc_relock", 32'(relock_cnt), 2);

    // glitch in FILTER
    do_reset();
    USR_PLL_LOCKED = 1'b1;
    tick(6); USR_PLL_LOCKED = 1'b0;
    tick(1); USR_PLL_LOCKED = 1'b1;
    tick(1); chk("glitch_e7_filter", 32'(state), 1);
    tick(1); chk("glitch_e8_wait", 32'(state), 0);
             chk("glitch_lock_lost", 32'(lock_lost), 0);
             chk("glitch_relock", 32'(relock_cnt), 0);
    tick(1);  chk("glitch_e9_filter", 32'(state), 1);
    tick(23); chk("glitch_e32_hold", 32'(state), 2);
    tick(1);  chk("glitch_e33_run", 32'(state), 3);

    // timeout with lock held low
    USR_PLL_LOCKED = 1'b0;
    do_reset();
    tick(1023); chk("to_e1023_wait", 32'(state), 0);
                chk("to_e1023_flag", 32'(timeout), 0);
    tick(1);    chk("to_e1024_fail", 32'(state), 5);
                chk("to_e1024_flag", 32'(timeout), 1);
    tick(5);    chk("to_stays_fail", 32'(state), 5);
    USR_PLL_LOCKED = 1'b1;
    tick(30);   chk("to_late_run", 32'(state), 3);
                chk("to_flag_kept", 32'(timeout), 1);
    clr_status = 1'b1; tick(1); clr_status = 1'b0;
    chk("to_flag_clr", 32'(timeout), 0);

    // randomized activity checked by the model
    run = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run == 0) begin
        USR_PLL_LOCKED = ~USR_PLL_LOCKED;
        if (USR_PLL_LOCKED) run = int'($urandom_range(1, 60));
        else if ($urandom_range(0, 30) == 0) run = int'($urandom_range(1020, 1060));
        else run = int'($urandom_range(1, 6));
      end
      run--;
      if ($urandom_range(0, 7) == 0) USR_PLL_LOCKED_STDY = ~USR_PLL_LOCKED_STDY;
      clr_status = ($urandom_range(0, 15) == 0);
      tick(1);
    end
    clr_status = 1'b0;

    // 300 loss events: relock_cnt saturates
    for (int i = 0; i < 300; i++) begin
      USR_PLL_LOCKED = 1'b1; tick(28);
      USR_PLL_LOCKED = 1'b0; tick(3);
    end
    chk("sat_relock", 32'(relock_cnt), 255);

    // asynchronous reset in the middle of HOLD
    USR_PLL_LOCKED = 1'b1;
    tick(21); chk("mid_hold", 32'(state), 2);
    do_reset();
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
